// File: rtl/bus_grant_decoder.sv
// rtl/bus_grant_decoder.sv - registered one-hot bus grant decoder with hold timeout and turnaround
//
// Turns the priority encoder's {valid, index} word into a one-hot grant
// and holds that grant for the owning master until one of three things happens:
// the master finishes, the master drops its request, or the master reaches its
// hold limit. Every change of owner passes through one idle turnaround cycle.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous reset, active low
//   enc_in       {valid, index} from the priority encoder
//   req          raw per-master request lines
//   bus_done     the owner is on its last transfer cycle
//   grant        one-hot grant, zero when the bus is unowned
//   grant_valid  high while any grant bit is set
//   grant_idx    index of the current owner, zero when unowned
//   timeout      one-cycle pulse on a forced release
module bus_grant_decoder #(
    parameter int N_MASTERS = 8,
    parameter int IDX_W     = 3,
    parameter int MAX_HOLD  = 64,
    parameter int CNT_W     = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IDX_W:0]       enc_in,
    input  logic [N_MASTERS-1:0] req,
    input  logic                 bus_done,
    output logic [N_MASTERS-1:0] grant,
    output logic                 grant_valid,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 timeout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWNED = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;

    // hold_cnt is zero on the grant edge, so the owner has held the bus for
    // MAX_HOLD cycles when the counter reaches MAX_HOLD-1.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    localparam logic [N_MASTERS-1:0] ONE_HOT_BASE = N_MASTERS'(1);

    logic [1:0]       state;
    logic [IDX_W-1:0] owner_idx;
    logic [CNT_W-1:0] hold_cnt;

    logic             enc_valid;
    logic [IDX_W-1:0] enc_idx;
    logic             owner_req;
    logic             hold_expired;

    assign enc_valid    = enc_in[IDX_W];
    assign enc_idx      = enc_in[IDX_W-1:0];
    assign owner_req    = req[owner_idx];
    assign hold_expired = (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            owner_idx   <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            timeout     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    timeout <= 1'b0;
                    if (enc_valid) begin
                        state       <= ST_OWNED;
                        owner_idx   <= enc_idx;
                        hold_cnt    <= '0;
                        grant       <= ONE_HOT_BASE << enc_idx;
                        grant_valid <= 1'b1;
                        grant_idx   <= enc_idx;
                    end
                end

                ST_OWNED: begin
                    // Completion and abandonment take precedence over the hold
                    // limit, so a master finishing on its last allowed cycle
                    // never sees a timeout pulse. enc_in is deliberately not
                    // looked at here: an owner cannot be preempted.
                    if (bus_done || !owner_req || hold_expired) begin
                        state       <= ST_TURN;
                        hold_cnt    <= '0;
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        grant_idx   <= '0;
                        timeout     <= !bus_done && owner_req;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                        timeout  <= 1'b0;
                    end
                end

                ST_TURN: begin
                    // Single dead cycle between owners; the request word is
                    // ignored so the earliest re-grant is the following edge.
                    state   <= ST_IDLE;
                    timeout <= 1'b0;
                end

                default: begin
                    state       <= ST_IDLE;
                    hold_cnt    <= '0;
                    grant       <= '0;
                    grant_valid <= 1'b0;
                    grant_idx   <= '0;
                    timeout     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_grant_decoder.sv
// tb/tb_bus_grant_decoder.sv - self-checking bench for bus_grant_decoder
module tb_bus_grant_decoder;

    localparam int MAX_HOLD = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] enc_in;
    logic [7:0] req;
    logic       bus_done;
    logic [7:0] grant;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic       timeout;

    int vectors    = 0;
    int miscompares = 0;

    bus_grant_decoder #(
        .N_MASTERS(8),
        .IDX_W    (3),
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (7)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enc_in     (enc_in),
        .req        (req),
        .bus_done   (bus_done),
        .grant      (grant),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the bus, for how many cycles, and whether
    // the bus is cooling down after a release.
    int owner    = -1;
    int age      = 0;
    bit cooldown = 1'b0;
    bit m_tout   = 1'b0;

    function automatic logic [7:0] model_grant();
        return (owner >= 0) ? 8'(1 << owner) : 8'h00;
    endfunction

    task automatic model_step(input bit r, input logic [3:0] e, input logic [7:0] q, input bit d);
        m_tout = 1'b0;
        if (!r) begin
            owner    = -1;
            cooldown = 1'b0;
        end else if (owner >= 0) begin
            if (d || !q[owner]) begin
                owner    = -1;
                cooldown = 1'b1;
            end else if (age == MAX_HOLD) begin
                owner    = -1;
                cooldown = 1'b1;
                m_tout   = 1'b1;
            end else begin
                age = age + 1;
            end
        end else if (cooldown) begin
            cooldown = 1'b0;
        end else if (e[3]) begin
            owner = int'(e[2:0]);
            age   = 1;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Checks the full output set against an expected grant and timeout;
    // grant_valid and grant_idx follow from the expected grant.
    task automatic check_outputs(input string tag, input logic [7:0] exp_g, input bit exp_t);
        logic [2:0] exp_i;
        exp_i = 3'd0;
        for (int b = 0; b < 8; b++) if (exp_g[b]) exp_i = 3'(b);
        check({tag, ".grant"}, grant, exp_g);
        check({tag, ".grant_valid"}, {7'd0, grant_valid}, {7'd0, |exp_g});
        check({tag, ".grant_idx"}, {5'd0, grant_idx}, {5'd0, exp_i});
        check({tag, ".timeout"}, {7'd0, timeout}, {7'd0, exp_t});
    endtask

    // Apply one cycle of inputs, advance the model, sample #1 after the edge.
    task automatic step(input bit r, input logic [3:0] e, input logic [7:0] q, input bit d);
        rst_n = r; enc_in = e; req = q; bus_done = d;
        @(posedge clk);
        model_step(r, e, q, d);
        #1;
        check_outputs("model", model_grant(), m_tout);
    endtask

    typedef struct {
        bit         r;
        logic [3:0] e;
        logic [7:0] q;
        bit         d;
        logic [7:0] exp_g;
        bit         exp_t;
    } vec_t;

    vec_t tbl[16];

    initial begin
        rst_n = 1'b0; enc_in = 4'h0; req = 8'h00; bus_done = 1'b0;

        tbl[0]  = '{0, 4'b1101, 8'h20, 0, 8'h00, 0}; // reset held, request pending
        tbl[1]  = '{0, 4'b1101, 8'h20, 0, 8'h00, 0};
        tbl[2]  = '{1, 4'b1101, 8'h20, 0, 8'h20, 0}; // grant one cycle after release
        tbl[3]  = '{1, 4'b0000, 8'h20, 0, 8'h20, 0}; // held
        tbl[4]  = '{1, 4'b0000, 8'h00, 0, 8'h00, 0}; // abandon, no timeout
        tbl[5]  = '{1, 4'b1011, 8'h08, 0, 8'h00, 0}; // turnaround ignores enc_in
        tbl[6]  = '{1, 4'b1011, 8'h08, 0, 8'h08, 0}; // grant master 3
        tbl[7]  = '{1, 4'b1000, 8'h09, 0, 8'h08, 0}; // no preemption
        tbl[8]  = '{1, 4'b1000, 8'h09, 1, 8'h00, 0}; // done
        tbl[9]  = '{1, 4'b1000, 8'h01, 0, 8'h00, 0}; // turnaround
        tbl[10] = '{1, 4'b1000, 8'h01, 0, 8'h01, 0}; // earliest re-grant
        tbl[11] = '{1, 4'b0000, 8'h01, 1, 8'h00, 0};
        tbl[12] = '{1, 4'b1010, 8'h04, 0, 8'h00, 0};
        tbl[13] = '{1, 4'b1010, 8'h04, 0, 8'h04, 0}; // grant master 2
        tbl[14] = '{0, 4'b1010, 8'h04, 0, 8'h00, 0}; // reset mid-ownership
        tbl[15] = '{1, 4'b0000, 8'h04, 0, 8'h00, 0}; // idle after release

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].r, tbl[i].e, tbl[i].q, tbl[i].d);
            check_outputs($sformatf("tbl%0d", i), tbl[i].exp_g, tbl[i].exp_t);
        end

        // Forced release after MAX_HOLD owned cycles.
        step(0, 4'b0000, 8'h00, 0);
        step(1, 4'b1000, 8'h01, 0);
        check_outputs("to_grant", 8'h01, 0);
        for (int i = 1; i < MAX_HOLD; i++) begin
            step(1, 4'b1111, 8'h01, 0);
            check_outputs("to_hold", 8'h01, 0);
        end
        step(1, 4'b1111, 8'h01, 0);
        check_outputs("to_release", 8'h00, 1);
        step(1, 4'b1111, 8'h01, 0);
        check_outputs("to_pulse_end", 8'h00, 0);
        step(1, 4'b1111, 8'h01, 0);
        check_outputs("to_regrant", 8'h80, 0);

        // Completion on the last allowed cycle wins over the timeout.
        step(0, 4'b0000, 8'h00, 0);
        step(1, 4'b1000, 8'h01, 0);
        for (int i = 1; i < MAX_HOLD; i++) step(1, 4'b0000, 8'h01, 0);
        step(1, 4'b0000, 8'h01, 1);
        check_outputs("done_at_limit", 8'h00, 0);
        step(1, 4'b0000, 8'h01, 0);
        check_outputs("done_at_limit_turn", 8'h00, 0);

        // Owner 6 is not preempted by a request for master 0.
        step(1, 4'b1110, 8'h40, 0);
        check_outputs("np_grant", 8'h40, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 4'b1000, 8'h41, 0);
            check_outputs("np_hold", 8'h40, 0);
        end
        step(1, 4'b1000, 8'h41, 1);
        check_outputs("np_done", 8'h00, 0);
        step(1, 4'b1000, 8'h41, 0);
        check_outputs("np_turn", 8'h00, 0);
        step(1, 4'b1000, 8'h41, 0);
        check_outputs("np_next", 8'h01, 0);

        // Random traffic against the model; alternating phases favour
        // short ownerships and long ones that reach the hold limit.
        for (int i = 0; i < 3000; i++) begin
            bit         r;
            bit         d;
            logic [3:0] e;
            logic [7:0] q;
            bit         long_phase;
            long_phase = ((i / 300) % 2) == 1;
            r = ($urandom_range(0, 99) != 0);
            e = 4'($urandom);
            if (long_phase) begin
                q = 8'hff;
                d = ($urandom_range(0, 199) == 0);
            end else begin
                q = 8'($urandom) | 8'($urandom) | 8'($urandom);
                d = ($urandom_range(0, 15) == 0);
            end
            step(r, e, q, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
